// File: rtl/axis_i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_i2c_pkg                                                     |
// | Purpose  : Shared types and constants for the AXI-Stream I2C master blocks. |
// | Contents : AXIS_DATA_WIDTH - command stream tdata width                     |
// |            ARB_MAX_BEATS   - default beats per grant of the arbiter         |
// |            arb_state_t     - arbiter FSM state encoding                     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package axis_i2c_pkg;

  localparam int AXIS_DATA_WIDTH = 8;
  localparam int ARB_MAX_BEATS   = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_i2c_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_i2c_rr_pick                                                 |
// | Purpose  : Combinational rotating-priority picker. Grants the first set     |
// |            request found when searching ptr, ptr+1, ... modulo N_REQ.       |
// | Ports    : req   - request vector, one bit per requester                    |
// |            ptr   - index of the highest-priority requester                  |
// |            gnt   - one-hot grant (all zeros when nothing requests)          |
// |            valid - high when any request is present                         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module axis_i2c_rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/axis_i2c_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_i2c_arbiter                                                 |
// | Purpose  : Round-robin arbiter sharing the I2C master's AXIS command input  |
// |            between N_REQ requesters. The grant is held for a whole burst    |
// |            (or MAX_BEATS beats) and data passes through with no latency.    |
// | Ports    : clk_i, rstn_i         - clock, synchronous active-low reset      |
// |            s_tdata_i/s_tvalid_i  - requester streams (k at [k*DW +: DW])    |
// |            s_tready_o            - requester readies                        |
// |            m_tdata_o/m_tvalid_o  - stream to the I2C master                 |
// |            m_tready_i            - ready from the I2C master                |
// |            grant_o               - one-hot current grant, zero when idle    |
// |            busy_o                - high while a grant is held               |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module axis_i2c_arbiter
  import axis_i2c_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int MAX_BEATS  = ARB_MAX_BEATS
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [N_REQ-1:0]            s_tvalid_i,
  output logic [N_REQ-1:0]            s_tready_o,
  output logic [DATA_WIDTH-1:0]       m_tdata_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  generate
    if (N_REQ < 2) begin : g_bad_n_req
      $error("axis_i2c_arbiter: N_REQ must be at least 2");
    end
    if (MAX_BEATS < 1) begin : g_bad_max_beats
      $error("axis_i2c_arbiter: MAX_BEATS must be at least 1");
    end
  endgenerate

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] grant, grant_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic [N_REQ-1:0] pick_gnt;
  logic             pick_valid;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] ptr_after;
  logic [CNT_W-1:0] beat_inc;
  logic             g_valid;
  logic             handshake;

  axis_i2c_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (s_tvalid_i),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Binary index of the one-hot grant; zero when nothing is granted.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
  end

  // Outside GRANT the mux parks on requester 0; tvalid is low then anyway.
  assign sel        = (state == GRANT) ? gidx : '0;
  assign m_tdata_o  = s_tdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign g_valid    = |(s_tvalid_i & grant);
  assign m_tvalid_o = (state == GRANT) && g_valid;
  assign s_tready_o = (state == GRANT) ? (grant & {N_REQ{m_tready_i}}) : '0;
  assign grant_o    = grant;
  assign busy_o     = (state == GRANT);

  assign handshake  = m_tvalid_o && m_tready_i;
  assign beat_inc   = beat_cnt + CNT_W'(1);
  assign ptr_after  = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt    = GRANT;
          grant_nxt    = pick_gnt;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        // A dropped valid before the first beat is a requester protocol
        // violation; the grant is deliberately held in that case.
        if ((handshake && (beat_inc == CNT_W'(MAX_BEATS))) ||
            (!g_valid && (beat_cnt != '0))) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          ptr_nxt      = ptr_after;
          beat_cnt_nxt = '0;
        end else if (handshake) begin
          beat_cnt_nxt = beat_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule
`default_nettype wire
